// File: rtl/arq_flow_multi_lt_pkg.sv
// Shared types, packet-type codes and helpers for the per-LT ARQ/flow controller.
package arq_flow_multi_lt_pkg;

  // Action codes presented to the packet encoder
  typedef enum logic [1:0] {
    ActNull  = 2'd0,
    ActNew   = 2'd1,
    ActRetx  = 2'd2,
    ActFlush = 2'd3
  } tx_action_e;

  // RX header/payload tracking
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHdr  = 1'b1
  } rx_state_e;

  // TYPE codes; 2, C and D are treated as reserved
  localparam logic [3:0] TypeNull = 4'h0;
  localparam logic [3:0] TypePoll = 4'h1;
  localparam logic [3:0] TypeDm1  = 4'h3;
  localparam logic [3:0] TypeDh1  = 4'h4;
  localparam logic [3:0] TypeHv1  = 4'h5;
  localparam logic [3:0] TypeHv2  = 4'h6;
  localparam logic [3:0] TypeHv3  = 4'h7;
  localparam logic [3:0] TypeDv   = 4'h8;
  localparam logic [3:0] TypeAux1 = 4'h9;
  localparam logic [3:0] TypeDm3  = 4'hA;
  localparam logic [3:0] TypeDh3  = 4'hB;
  localparam logic [3:0] TypeDm5  = 4'hE;
  localparam logic [3:0] TypeDh5  = 4'hF;

  // Packets carrying a sequenced payload
  function automatic logic is_data(logic [3:0] t);
    logic r;
    case (t)
      TypeDm1, TypeDh1, TypeDv, TypeDm3, TypeDh3, TypeDm5, TypeDh5: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Packets that never produce a payload verdict
  function automatic logic is_ctrl(logic [3:0] t);
    logic r;
    case (t)
      TypeNull, TypePoll, TypeHv1, TypeAux1, TypeHv2, TypeHv3: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arq_flow_multi_lt_if.sv
// Decoder/encoder/host-side bus of the ARQ/flow controller.
// ESCO_EN adds the eSCO window inputs.
interface arq_flow_multi_lt_if #(
  parameter int unsigned NUM_LT     = 8,
  parameter int unsigned LT_W       = 3,
  parameter int unsigned FLUSH_TO_W = 16
);
  logic                  conn_init_p;
  logic [LT_W-1:0]       conn_lt;
  logic                  is_master;
  logic                  rx_hdr_p;
  logic                  rx_hec_ok;
  logic [LT_W-1:0]       rx_lt_addr;
  logic [3:0]            rx_pktype;
  logic                  rx_flow;
  logic                  rx_arqn;
  logic                  rx_seqn;
  logic                  rx_end_p;
  logic                  rx_crc_ok;
  logic                  rx_timeout_p;
  logic [NUM_LT-1:0]     host_rxbuf_ok;
  logic                  tx_req_p;
  logic [LT_W-1:0]       tx_lt_addr;
  logic                  tx_has_data;
  logic                  flush_p;
  logic [LT_W-1:0]       flush_lt;
  logic [FLUSH_TO_W-1:0] flush_to;
  logic                  slot_p;
`ifdef ESCO_EN
  logic [LT_W-1:0]       esco_lt;
  logic                  esco_window;
  logic                  esco_win_end_p;
  logic                  esco_type_ok;
`endif
  logic                  tx_valid;
  logic [1:0]            tx_action;
  logic                  tx_seqn;
  logic                  tx_arqn;
  logic                  tx_flow;
  logic                  rx_accept_p;
  logic                  rx_ignore_p;
  logic                  rx_reject_p;
  logic                  payload_ack_p;
  logic                  flush_done_p;
  logic [LT_W-1:0]       ack_lt;
  logic [NUM_LT-1:0]     remote_stop;

  // Link-controller side
  modport master (
`ifdef ESCO_EN
    output esco_lt, esco_window, esco_win_end_p, esco_type_ok,
`endif
    output conn_init_p, conn_lt, is_master, rx_hdr_p, rx_hec_ok, rx_lt_addr, rx_pktype,
    output rx_flow, rx_arqn, rx_seqn, rx_end_p, rx_crc_ok, rx_timeout_p, host_rxbuf_ok,
    output tx_req_p, tx_lt_addr, tx_has_data, flush_p, flush_lt, flush_to, slot_p,
    input  tx_valid, tx_action, tx_seqn, tx_arqn, tx_flow, rx_accept_p, rx_ignore_p,
    input  rx_reject_p, payload_ack_p, flush_done_p, ack_lt, remote_stop
  );

  // ARQ controller side
  modport slave (
`ifdef ESCO_EN
    input  esco_lt, esco_window, esco_win_end_p, esco_type_ok,
`endif
    input  conn_init_p, conn_lt, is_master, rx_hdr_p, rx_hec_ok, rx_lt_addr, rx_pktype,
    input  rx_flow, rx_arqn, rx_seqn, rx_end_p, rx_crc_ok, rx_timeout_p, host_rxbuf_ok,
    input  tx_req_p, tx_lt_addr, tx_has_data, flush_p, flush_lt, flush_to, slot_p,
    output tx_valid, tx_action, tx_seqn, tx_arqn, tx_flow, rx_accept_p, rx_ignore_p,
    output rx_reject_p, payload_ack_p, flush_done_p, ack_lt, remote_stop
  );
endinterface

// File: rtl/arq_flow_multi_lt_ctx.sv
// One logical-transport state slice: SEQN, SEQN_old, ARQN, remote FLOW,
// outstanding payload, flush-pending and the auto-flush slot counter.
module arq_flow_multi_lt_ctx #(
  parameter int unsigned FLUSH_TO_W = 16
) (
  input  logic                  clk_6M,
  input  logic                  rstz,
  input  logic                  init_i,
  input  logic                  arqn_set_i,
  input  logic                  arqn_clr_i,
  input  logic                  seqn_old_wr_i,
  input  logic                  seqn_old_i,
  input  logic                  rstop_wr_i,
  input  logic                  rstop_i,
  input  logic                  ack_i,
  input  logic                  seqn_tgl_i,
  input  logic                  tx_new_i,
  input  logic                  tx_flush_i,
  input  logic                  flush_i,
  input  logic                  slot_i,
  input  logic [FLUSH_TO_W-1:0] flush_to_i,
  output logic                  seqn_o,
  output logic                  seqn_old_o,
  output logic                  arqn_o,
  output logic                  rstop_o,
  output logic                  outst_o,
  output logic                  flush_pend_o,
  output logic                  ack_hit_o,
  output logic                  ack_flush_o
);
  logic                  seqn_q, seqn_d;
  logic                  seqn_old_q, seqn_old_d;
  logic                  arqn_q, arqn_d;
  logic                  rstop_q, rstop_d;
  logic                  outst_q, outst_d;
  logic                  out_flush_q, out_flush_d;
  logic                  fpend_q, fpend_d;
  logic [FLUSH_TO_W-1:0] rtx_q, rtx_d;
  logic                  to_hit;

  assign ack_hit_o   = ack_i & outst_q & ~init_i;
  assign ack_flush_o = ack_hit_o & out_flush_q;
  assign to_hit      = outst_q & (flush_to_i != '0) & (rtx_q == flush_to_i);

  // Next-state; conn_init overrides every other event
  always_comb begin
    seqn_d      = seqn_q ^ (ack_hit_o ^ seqn_tgl_i);
    seqn_old_d  = seqn_old_wr_i ? seqn_old_i : seqn_old_q;
    arqn_d      = arqn_clr_i ? 1'b0 : (arqn_set_i ? 1'b1 : arqn_q);
    rstop_d     = rstop_wr_i ? rstop_i : rstop_q;
    outst_d     = outst_q;
    out_flush_d = out_flush_q;
    fpend_d     = fpend_q;
    rtx_d       = rtx_q;
    // An ACK means the payload got through, so any pending flush is moot
    if (ack_hit_o) begin
      outst_d     = 1'b0;
      out_flush_d = 1'b0;
      fpend_d     = 1'b0;
      rtx_d       = '0;
    end else begin
      if (flush_i || to_hit) fpend_d = 1'b1;
      if (slot_i && outst_q && (rtx_q != '1)) rtx_d = rtx_q + 1'b1;
    end
    if (tx_new_i || tx_flush_i) begin
      outst_d     = 1'b1;
      out_flush_d = tx_flush_i;
    end
    if (init_i) begin
      seqn_d      = 1'b1;
      seqn_old_d  = 1'b0;
      arqn_d      = 1'b0;
      rstop_d     = 1'b0;
      outst_d     = 1'b0;
      out_flush_d = 1'b0;
      fpend_d     = 1'b0;
      rtx_d       = '0;
    end
  end

  // State registers
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      seqn_q      <= 1'b1;
      seqn_old_q  <= 1'b0;
      arqn_q      <= 1'b0;
      rstop_q     <= 1'b0;
      outst_q     <= 1'b0;
      out_flush_q <= 1'b0;
      fpend_q     <= 1'b0;
      rtx_q       <= '0;
    end else begin
      seqn_q      <= seqn_d;
      seqn_old_q  <= seqn_old_d;
      arqn_q      <= arqn_d;
      rstop_q     <= rstop_d;
      outst_q     <= outst_d;
      out_flush_q <= out_flush_d;
      fpend_q     <= fpend_d;
      rtx_q       <= rtx_d;
    end
  end

  assign seqn_o       = seqn_q;
  assign seqn_old_o   = seqn_old_q;
  assign arqn_o       = arqn_q;
  assign rstop_o      = rstop_q;
  assign outst_o      = outst_q;
  assign flush_pend_o = fpend_q;

endmodule

// File: rtl/arq_flow_multi_lt.sv
// Per-LT ARQ/flow controller: RX header/payload judging, TX action selection
// and per-LT event decode onto NUM_LT context slices.
// Optional feature macro: ESCO_EN (eSCO window acceptance rules).
module arq_flow_multi_lt
  import arq_flow_multi_lt_pkg::*;
#(
  parameter int unsigned NUM_LT     = 8,
  parameter int unsigned LT_W       = 3,
  parameter int unsigned FLUSH_TO_W = 16
) (
  input logic                clk_6M,
  input logic                rstz,
  arq_flow_multi_lt_if.slave bus
);
  rx_state_e       st_q, st_d;
  logic [LT_W-1:0] pend_lt_q, pend_lt_d;
  logic [3:0]      pend_type_q, pend_type_d;
  logic            pend_seqn_q, pend_seqn_d;

  logic [NUM_LT-1:0] init_v, arqn_set_v, arqn_clr_v, sold_wr_v, rstop_wr_v, ack_v, stgl_v;
  logic [NUM_LT-1:0] tx_new_v, tx_flush_v, flush_v;
  logic [NUM_LT-1:0] seqn_v, seqn_old_v, arqn_v, rstop_v, outst_v, fpend_v;
  logic [NUM_LT-1:0] ack_hit_v, ack_flush_v;

  logic            hdr_fire, hdr_addr, end_fire, abort;
  logic            accept_d, ignore_d, reject_d;
  logic            accept_q, ignore_q, reject_q;
  logic            pack_q, fdone_q, tx_valid_q;
  logic            tx_seqn_q, tx_arqn_q, tx_flow_q;
  logic [LT_W-1:0] ack_lt_q;
  tx_action_e      act, tx_action_q;

`ifdef ESCO_EN
  logic esco_got_q, esco_got_d;
`endif

  // Broadcast (LT 0) is always treated as addressed
  assign hdr_addr = (bus.rx_lt_addr == bus.tx_lt_addr) || (bus.rx_lt_addr == '0);
  assign hdr_fire = bus.rx_hdr_p & ~bus.rx_timeout_p;
  assign end_fire = (st_q == StHdr) & bus.rx_end_p & ~bus.rx_timeout_p;
  assign abort    = (st_q == StHdr) & ~end_fire & (bus.rx_timeout_p | bus.rx_hdr_p);

  // RX FSM next-state: track the header of a payload awaiting its verdict
  always_comb begin
    st_d        = st_q;
    pend_lt_d   = pend_lt_q;
    pend_type_d = pend_type_q;
    pend_seqn_d = pend_seqn_q;
    if (hdr_fire && bus.rx_hec_ok && hdr_addr) begin
      st_d        = StHdr;
      pend_lt_d   = bus.rx_lt_addr;
      pend_type_d = bus.rx_pktype;
      pend_seqn_d = bus.rx_seqn;
    end else if (end_fire || abort) begin
      st_d = StIdle;
    end
  end

  // RX event decode onto per-LT strobes and verdicts
  always_comb begin
    init_v     = '0;
    arqn_set_v = '0;
    arqn_clr_v = '0;
    sold_wr_v  = '0;
    rstop_wr_v = '0;
    ack_v      = '0;
    stgl_v     = '0;
    flush_v    = '0;
    accept_d   = 1'b0;
    ignore_d   = 1'b0;
    reject_d   = 1'b0;
`ifdef ESCO_EN
    esco_got_d = esco_got_q;
`endif
    if (bus.conn_init_p) init_v[bus.conn_lt] = 1'b1;
    if (bus.flush_p) flush_v[bus.flush_lt] = 1'b1;
    if (bus.rx_timeout_p) arqn_clr_v[bus.tx_lt_addr] = 1'b1;
    if (hdr_fire) begin
      if (!bus.rx_hec_ok) begin
        arqn_clr_v[bus.tx_lt_addr] = 1'b1;
      end else if (!hdr_addr) begin
        if (bus.is_master) arqn_clr_v[bus.tx_lt_addr] = 1'b1;
      end else begin
        rstop_wr_v[bus.rx_lt_addr] = 1'b1;
        ack_v[bus.rx_lt_addr]      = bus.rx_arqn;
      end
    end
    if (abort) begin
      if (is_data(pend_type_q)) begin
        reject_d              = 1'b1;
        arqn_clr_v[pend_lt_q] = 1'b1;
      end
    end else if (end_fire) begin
`ifdef ESCO_EN
      if (bus.esco_window && (pend_lt_q == bus.esco_lt)) begin
        if (bus.rx_crc_ok && bus.esco_type_ok) begin
          arqn_set_v[pend_lt_q] = 1'b1;
          if (esco_got_q) begin
            ignore_d = 1'b1;
          end else begin
            accept_d             = 1'b1;
            sold_wr_v[pend_lt_q] = 1'b1;
            esco_got_d           = 1'b1;
          end
        end else begin
          reject_d              = 1'b1;
          arqn_clr_v[pend_lt_q] = 1'b1;
        end
      end else
`endif
      if (is_data(pend_type_q)) begin
        if (pend_seqn_q == seqn_old_v[pend_lt_q]) begin
          ignore_d              = 1'b1;
          arqn_set_v[pend_lt_q] = 1'b1;
        end else if (bus.rx_crc_ok && bus.host_rxbuf_ok[pend_lt_q]) begin
          accept_d              = 1'b1;
          sold_wr_v[pend_lt_q]  = 1'b1;
          arqn_set_v[pend_lt_q] = 1'b1;
        end else begin
          reject_d              = 1'b1;
          arqn_clr_v[pend_lt_q] = 1'b1;
        end
      end else if (!is_ctrl(pend_type_q)) begin
        reject_d              = 1'b1;
        arqn_clr_v[pend_lt_q] = 1'b1;
      end
    end
`ifdef ESCO_EN
    if (bus.esco_win_end_p) begin
      stgl_v[bus.esco_lt] = 1'b1;
      esco_got_d          = 1'b0;
    end
`endif
    // A connection restart on the pending LT swallows its verdict
    if (init_v[pend_lt_q]) begin
      accept_d = 1'b0;
      ignore_d = 1'b0;
      reject_d = 1'b0;
    end
    // Broadcasts are never acknowledged
    arqn_set_v[0] = 1'b0;
    arqn_clr_v[0] = 1'b0;
  end

  // TX action in priority order on the current state of tx_lt_addr
  always_comb begin
    tx_new_v   = '0;
    tx_flush_v = '0;
    act        = ActNull;
    if (rstop_v[bus.tx_lt_addr])      act = ActNull;
    else if (fpend_v[bus.tx_lt_addr]) act = ActFlush;
    else if (outst_v[bus.tx_lt_addr]) act = ActRetx;
    else if (bus.tx_has_data)         act = ActNew;
    if (bus.tx_req_p) begin
      tx_new_v[bus.tx_lt_addr]   = (act == ActNew);
      tx_flush_v[bus.tx_lt_addr] = (act == ActFlush);
    end
  end

  for (genvar i = 0; i < NUM_LT; i++) begin : g_lt
    arq_flow_multi_lt_ctx #(
      .FLUSH_TO_W(FLUSH_TO_W)
    ) u_ctx (
      .clk_6M       (clk_6M),
      .rstz         (rstz),
      .init_i       (init_v[i]),
      .arqn_set_i   (arqn_set_v[i]),
      .arqn_clr_i   (arqn_clr_v[i]),
      .seqn_old_wr_i(sold_wr_v[i]),
      .seqn_old_i   (pend_seqn_q),
      .rstop_wr_i   (rstop_wr_v[i]),
      .rstop_i      (~bus.rx_flow),
      .ack_i        (ack_v[i]),
      .seqn_tgl_i   (stgl_v[i]),
      .tx_new_i     (tx_new_v[i]),
      .tx_flush_i   (tx_flush_v[i]),
      .flush_i      (flush_v[i]),
      .slot_i       (bus.slot_p),
      .flush_to_i   (bus.flush_to),
      .seqn_o       (seqn_v[i]),
      .seqn_old_o   (seqn_old_v[i]),
      .arqn_o       (arqn_v[i]),
      .rstop_o      (rstop_v[i]),
      .outst_o      (outst_v[i]),
      .flush_pend_o (fpend_v[i]),
      .ack_hit_o    (ack_hit_v[i]),
      .ack_flush_o  (ack_flush_v[i])
    );
  end

  // RX FSM state register
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      st_q        <= StIdle;
      pend_lt_q   <= '0;
      pend_type_q <= '0;
      pend_seqn_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      pend_lt_q   <= pend_lt_d;
      pend_type_q <= pend_type_d;
      pend_seqn_q <= pend_seqn_d;
    end
  end

`ifdef ESCO_EN
  // First-good-packet tracker for the current eSCO window
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) esco_got_q <= 1'b0;
    else       esco_got_q <= esco_got_d;
  end
`endif

  // Registered outputs; TX header bits hold until the next tx_valid
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      tx_valid_q  <= 1'b0;
      tx_action_q <= ActNull;
      tx_seqn_q   <= 1'b0;
      tx_arqn_q   <= 1'b0;
      tx_flow_q   <= 1'b0;
      accept_q    <= 1'b0;
      ignore_q    <= 1'b0;
      reject_q    <= 1'b0;
      pack_q      <= 1'b0;
      fdone_q     <= 1'b0;
      ack_lt_q    <= '0;
    end else begin
      tx_valid_q <= bus.tx_req_p;
      if (bus.tx_req_p) begin
        tx_action_q <= act;
        tx_seqn_q   <= seqn_v[bus.tx_lt_addr];
        tx_arqn_q   <= arqn_v[bus.tx_lt_addr];
        tx_flow_q   <= bus.host_rxbuf_ok[bus.tx_lt_addr];
      end
      accept_q <= accept_d;
      ignore_q <= ignore_d;
      reject_q <= reject_d;
      pack_q   <= |(ack_hit_v & ~ack_flush_v);
      fdone_q  <= |ack_flush_v;
      if (|ack_hit_v) ack_lt_q <= bus.rx_lt_addr;
    end
  end

  assign bus.tx_valid      = tx_valid_q;
  assign bus.tx_action     = tx_action_q;
  assign bus.tx_seqn       = tx_seqn_q;
  assign bus.tx_arqn       = tx_arqn_q;
  assign bus.tx_flow       = tx_flow_q;
  assign bus.rx_accept_p   = accept_q;
  assign bus.rx_ignore_p   = ignore_q;
  assign bus.rx_reject_p   = reject_q;
  assign bus.payload_ack_p = pack_q;
  assign bus.flush_done_p  = fdone_q;
  assign bus.ack_lt        = ack_lt_q;
  assign bus.remote_stop   = rstop_v;

endmodule
